// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared FSM encodings and constants for the sequential divider
package seq_divider_pkg;
   localparam int DEF_W = 32;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [63:0] DBZ_QUO = '1;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a requester and the divider
interface seq_divider_if
   import seq_divider_pkg::*;
#(parameter int W = DEF_W);
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   modport master(output start, dividend, divisor, input quotient, remainder, busy, done, div_by_zero);
   modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring division step
module div_step #(parameter int W = 32) (
   input  logic [W:0]   i_rem,
   input  logic [W-1:0] i_div,
   input  logic         i_bit,
   output logic [W:0]   o_rem,
   output logic         o_qbit
);
   logic [W:0]   w_sh;
   logic [W+1:0] w_diff;
   // a set i_rem MSB means the true shifted value exceeds any divisor
   always_comb begin
      w_sh   = {i_rem[W-1:0], i_bit};
      w_diff = {1'b0, w_sh} - {2'b00, i_div};
      o_qbit = i_rem[W] | ~w_diff[W+1];
      o_rem  = o_qbit ? w_diff[W:0] : w_sh;
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: W-cycle restoring unsigned divider with divide-by-zero bypass
module seq_divider
   import seq_divider_pkg::*;
#(parameter int W = DEF_W) (
   input logic          clk,
   input logic          rst,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(W);
   logic [1:0]    r_state;
   logic [W:0]    r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_div;
   logic [W-1:0]  r_q_out;
   logic [W-1:0]  r_r_out;
   logic [CW-1:0] r_cnt;
   logic          r_dbz;
   logic [W:0]    w_rem_nxt;
   logic          w_qbit;
   div_step #(.W(W)) u_step (
      .i_rem (r_rem),
      .i_div (r_div),
      .i_bit (r_quo[W-1]),
      .o_rem (w_rem_nxt),
      .o_qbit(w_qbit)
   );
   // r_quo shifts dividend bits out the top while quotient bits enter the bottom
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_q_out <= '0;
         r_r_out <= '0;
         r_cnt   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               if (bus.divisor == '0) begin
                  r_state <= S_FIN;
                  r_q_out <= DBZ_QUO[W-1:0];
                  r_r_out <= bus.dividend;
                  r_dbz   <= 1'b1;
               end else begin
                  r_state <= S_RUN;
                  r_quo   <= bus.dividend;
                  r_div   <= bus.divisor;
                  r_rem   <= '0;
                  r_cnt   <= CW'(W - 1);
               end
            end
            S_RUN: begin
               r_rem <= w_rem_nxt;
               r_quo <= {r_quo[W-2:0], w_qbit};
               if (r_cnt == '0) begin
                  r_state <= S_FIN;
                  r_q_out <= {r_quo[W-2:0], w_qbit};
                  r_r_out <= w_rem_nxt[W-1:0];
                  r_dbz   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign bus.quotient    = r_q_out;
   assign bus.remainder   = r_r_out;
   assign bus.div_by_zero = r_dbz;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = (r_state == S_FIN);
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model
module tb_seq_divider;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   seq_divider_if #(.W(32)) bus();
   seq_divider #(.W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_q"}, 64'(bus.quotient), 64'd0);
      chk({tag, "_r"}, 64'(bus.remainder), 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
   endtask
   // called at a negedge while idle; returns at the negedge after the done cycle
   task automatic run_op(input logic [31:0] dd, input logic [31:0] dv);
      logic [31:0] eq, er;
      logic        edbz;
      int          lat, cyc, nbusy;
      edbz = (dv == 0);
      eq   = edbz ? 32'hFFFF_FFFF : dd / dv;
      er   = edbz ? dd : dd % dv;
      lat  = edbz ? 1 : 33;
      bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
      cyc = 1; nbusy = 0;
      while (!bus.done && cyc < 60) begin
         nbusy += int'(bus.busy);
         @(negedge clk);
         cyc++;
      end
      nbusy += int'(bus.busy);
      chk("latency", 64'(cyc), 64'(lat));
      chk("busy_cycles", 64'(nbusy), 64'(lat));
      chk("quotient", 64'(bus.quotient), 64'(eq));
      chk("remainder", 64'(bus.remainder), 64'(er));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(edbz));
      if (!edbz) begin
         chk("identity", 64'(bus.quotient) * 64'(dv) + 64'(bus.remainder), 64'(dd));
         chk("rem_lt_div", 64'(bus.remainder < dv), 64'd1);
      end
      @(negedge clk);
      chk("done_single", 64'(bus.done), 64'd0);
      chk("busy_after", 64'(bus.busy), 64'd0);
      chk("hold_q", 64'(bus.quotient), 64'(eq));
      chk("hold_r", 64'(bus.remainder), 64'(er));
   endtask
   initial begin
      int ndone, dcyc, mode;
      logic [31:0] dd, dv;
      n_chk = 0; n_fail = 0;
      rst = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      #2;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      run_op(32'd100, 32'd7);
      run_op(32'h1234_5678, 32'd0);
      run_op(32'hFFFF_FFFF, 32'd1);
      run_op(32'd5, 32'd9);
      run_op(32'd0, 32'd3);
      // start pulse while busy must be dropped, not queued
      bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd10;
      @(posedge clk);
      @(negedge clk);
      ndone = 0; dcyc = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.done) begin ndone++; dcyc = c; end
         bus.start = (c == 10);
         bus.dividend = (c == 10) ? 32'd7 : 32'd0;
         bus.divisor = (c == 10) ? 32'd7 : 32'd0;
         @(negedge clk);
      end
      chk("busy_start_ndone", 64'(ndone), 64'd1);
      chk("busy_start_dcyc", 64'(dcyc), 64'd33);
      chk("busy_start_q", 64'(bus.quotient), 64'd100);
      chk("busy_start_r", 64'(bus.remainder), 64'd0);
      run_op(32'd81, 32'd9);
      // start in the done cycle is ignored
      bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      dcyc = 1;
      while (!bus.done && dcyc < 60) begin @(negedge clk); dcyc++; end
      chk("fin_start_lat", 64'(dcyc), 64'd33);
      bus.start = 1'b1; bus.dividend = 32'd3; bus.divisor = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("fin_start_busy", 64'(bus.busy), 64'd0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin ndone += int'(bus.done); @(negedge clk); end
      chk("fin_start_ndone", 64'(ndone), 64'd0);
      chk("fin_start_q", 64'(bus.quotient), 64'd10);
      // reset in the middle of a run
      bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd10;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin ndone += int'(bus.done); @(negedge clk); end
      chk("reset_no_done", 64'(ndone), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_op(32'd9, 32'd4);
      for (int i = 0; i < 1000; i++) begin
         mode = int'($urandom_range(0, 9));
         dd = (mode == 9) ? 32'($urandom_range(0, 255)) : $urandom;
         dv = (mode == 0) ? 32'd0 : (mode == 1) ? 32'd1 : (mode == 2) ? dd :
              (mode == 3) ? 32'($urandom_range(1, 15)) : (mode == 4) ? dd + 32'd1 : $urandom;
         run_op(dd, dv);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
